// File: rtl/mem_port_sched.sv
// Memory read-port scheduler: shares one byte-wide read port between
// instruction fetch (fixed 4-byte word) and data load (1..8 bytes).
// One byte is read per cycle. The assembled little-endian result is
// published together with a one-cycle ack.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | port parked at address 0, arbitrating the eligible requests
// FETCH  | streaming IF_BYTES bytes into the instruction assembly reg
// LOAD   | streaming 1..LD_MAX bytes into the load assembly reg
module mem_port_sched #(
  parameter int ADDR_W   = 10,
  parameter int IF_BYTES = 4,
  parameter int LD_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic [7:0]            mem_rdata,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ack,
  output logic [8*IF_BYTES-1:0] if_ins,
  input  logic                  ld_req,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [3:0]            ld_bytes,
  output logic                  ld_ack,
  output logic [8*LD_MAX-1:0]   ld_data,
  output logic                  busy
);

  localparam int CNT_W = $clog2(LD_MAX);
  localparam int LEN_W = CNT_W + 1;
  localparam logic [LEN_W-1:0] IF_LEN     = LEN_W'(IF_BYTES);
  localparam logic [LEN_W-1:0] LD_MAX_LEN = LEN_W'(LD_MAX);
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LD = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [8*LD_MAX-1:0]     asm_q, asm_d;
  logic [8*IF_BYTES-1:0]   if_ins_q, if_ins_d;
  logic [8*LD_MAX-1:0]     ld_data_q, ld_data_d;
  logic                    if_ack_q, if_ack_d;
  logic                    ld_ack_q, ld_ack_d;

  logic                    if_elig, ld_elig;
  logic                    grant_if, grant_ld;
  logic [LEN_W-1:0]        ld_len;
  logic                    last_beat;

  // Read address: parked at zero when idle, base plus beat index otherwise (wraps naturally).
  always_comb begin
    if (state_q == S_IDLE) begin
      mem_raddr = '0;
    end else begin
      mem_raddr = base_q + {{(ADDR_W-CNT_W){1'b0}}, cnt_q};
    end
  end

  // Next-state logic: arbitration in IDLE, byte-lane capture while transferring.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    if_ins_d     = if_ins_q;
    ld_data_d    = ld_data_q;
    if_ack_d     = 1'b0;
    ld_ack_d     = 1'b0;

    // A port whose ack is showing this cycle must not be re-granted on the same edge.
    if_elig  = if_req && !if_ack_q;
    ld_elig  = ld_req && !ld_ack_q;
    grant_if = if_elig && (!ld_elig || (last_grant_q == GRANT_LD));
    grant_ld = ld_elig && !grant_if;

    if ((ld_bytes == '0) || (ld_bytes > LD_MAX_LEN)) begin
      ld_len = LD_MAX_LEN;
    end else begin
      ld_len = ld_bytes;
    end

    last_beat = ({1'b0, cnt_q} == (len_q - LEN_W'(1)));

    case (state_q)
      S_IDLE: begin
        // Round-robin pointer only moves when both sides actually contended.
        if (if_elig && ld_elig) begin
          last_grant_d = grant_if ? GRANT_IF : GRANT_LD;
        end
        if (grant_if) begin
          base_d  = if_addr;
          len_d   = IF_LEN;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = S_FETCH;
        end else if (grant_ld) begin
          base_d  = ld_addr;
          len_d   = ld_len;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_FETCH, S_LOAD: begin
        asm_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_beat) begin
          state_d = S_IDLE;
          if (state_q == S_FETCH) begin
            if_ack_d = 1'b1;
            if_ins_d = asm_d[8*IF_BYTES-1:0];
          end else begin
            ld_ack_d  = 1'b1;
            ld_data_d = asm_d;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_LD;
      base_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      asm_q        <= '0;
      if_ins_q     <= '0;
      ld_data_q    <= '0;
      if_ack_q     <= 1'b0;
      ld_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      if_ins_q     <= if_ins_d;
      ld_data_q    <= ld_data_d;
      if_ack_q     <= if_ack_d;
      ld_ack_q     <= ld_ack_d;
    end
  end

  assign if_ack  = if_ack_q;
  assign ld_ack  = ld_ack_q;
  assign if_ins  = if_ins_q;
  assign ld_data = ld_data_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: byte memory model, ack scoreboard, scenario tasks.
module tb_mem_port_sched;

  logic        clk;
  logic        reset;
  logic [9:0]  mem_raddr;
  logic [7:0]  mem_rdata;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_ins;
  logic        ld_req;
  logic [9:0]  ld_addr;
  logic [3:0]  ld_bytes;
  logic        ld_ack;
  logic [63:0] ld_data;
  logic        busy;

  logic [7:0]  mem [1024];
  int          cyc;
  int          errors;
  int          checks;

  typedef struct {
    bit          is_ld;
    logic [63:0] data;
    int          ack_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] mon_got;

  mem_port_sched dut (
    .clk       (clk),
    .reset     (reset),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_ins    (if_ins),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_bytes  (ld_bytes),
    .ld_ack    (ld_ack),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  assign mem_rdata = mem[mem_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every ack pops the oldest expectation and compares port, data and timing.
  always @(negedge clk) begin
    if (if_ack || ld_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: if_ack=%0b ld_ack=%0b at cycle %0d, required no ack", if_ack, ld_ack, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({if_ack, ld_ack} !== (mon_e.is_ld ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL ack_port: got if_ack=%0b ld_ack=%0b, required %s ack", if_ack, ld_ack, mon_e.is_ld ? "ld" : "if");
        end
        checks++;
        mon_got = mon_e.is_ld ? ld_data : {32'h0, if_ins};
        if (mon_got !== mon_e.data) begin
          errors++;
          $display("FAIL ack_data: got %h, required %h", mon_got, mon_e.data);
        end
        checks++;
        if (cyc !== mon_e.ack_cyc) begin
          errors++;
          $display("FAIL ack_cycle: got cycle %0d, required cycle %0d", cyc, mon_e.ack_cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Waits on negedges for the chosen ack and releases that request when it shows.
  task automatic wait_ack(input bit want_ld, input int bound, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < bound && !seen; n++) begin
      @(negedge clk);
      if (want_ld ? ld_ack : if_ack) seen = 1'b1;
    end
    if (want_ld) ld_req = 1'b0;
    else         if_req = 1'b0;
  endtask

  task automatic push_exp(input bit is_ld, input logic [63:0] data, input int ack_cyc);
    exp_t e;
    e.is_ld   = is_ld;
    e.data    = data;
    e.ack_cyc = ack_cyc;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_raddr !== 10'd0) begin errors++; $display("FAIL reset_raddr: got %0d, required 0", mem_raddr); end
    checks++;
    if ({if_ack, ld_ack, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got if_ack/ld_ack/busy=%b, required 000", {if_ack, ld_ack, busy}); end
    checks++;
    if (if_ins !== 32'h0) begin errors++; $display("FAIL reset_if_ins: got %h, required 0", if_ins); end
    checks++;
    if (ld_data !== 64'h0) begin errors++; $display("FAIL reset_ld_data: got %h, required 0", ld_data); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_fetch();
    int e;
    bit seen;
    @(posedge clk); #1;
    if_addr = 10'd0;
    if_req  = 1'b1;
    e = cyc + 1;
    push_exp(1'b0, 64'h03020100, e + 4);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ((mem_raddr !== 10'(k)) || (busy !== 1'b1)) begin
        errors++;
        $display("FAIL fetch_beat%0d: got raddr=%0d busy=%0b, required raddr=%0d busy=1", k, mem_raddr, busy, k);
      end
    end
    wait_ack(1'b0, 20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL fetch_timeout: no if_ack within 20 cycles, required one"); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fetch_ack_busy: got busy=%0b in ack cycle, required 0", busy); end
  endtask

  task automatic test_load();
    logic [3:0]  nb  [3] = '{4'd8, 4'd3, 4'd0};
    int          len [3] = '{8, 3, 8};
    logic [63:0] val [3] = '{64'h0F0E0D0C0B0A0908, 64'h0A0908, 64'h0F0E0D0C0B0A0908};
    bit seen;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      ld_addr  = 10'd8;
      ld_bytes = nb[t];
      ld_req   = 1'b1;
      push_exp(1'b1, val[t], cyc + 1 + len[t]);
      wait_ack(1'b1, 30, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL load%0d_timeout: no ld_ack within 30 cycles, required one", t); end
    end
  endtask

  task automatic test_arbitration();
    int e;
    bit seen;
    // Tie straight after reset: fetch first, then load on the fetch-ack closing edge.
    @(posedge clk); #1;
    if_addr  = 10'd12;
    ld_addr  = 10'd0;
    ld_bytes = 4'd2;
    if_req   = 1'b1;
    ld_req   = 1'b1;
    e = cyc + 1;
    push_exp(1'b0, 64'h0F0E0D0C, e + 4);
    push_exp(1'b1, 64'h0100,     e + 7);
    wait_ack(1'b0, 20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL arb1_if_timeout: no if_ack within 20 cycles, required one"); end
    wait_ack(1'b1, 20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL arb1_ld_timeout: no ld_ack within 20 cycles, required one"); end
    // Second tie: load wins this time, fetch follows on the load-ack closing edge.
    @(posedge clk); #1;
    if_addr  = 10'd8;
    ld_addr  = 10'd4;
    ld_bytes = 4'd1;
    if_req   = 1'b1;
    ld_req   = 1'b1;
    e = cyc + 1;
    push_exp(1'b1, 64'h04,       e + 1);
    push_exp(1'b0, 64'h0B0A0908, e + 6);
    wait_ack(1'b1, 20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL arb2_ld_timeout: no ld_ack within 20 cycles, required one"); end
    wait_ack(1'b0, 20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL arb2_if_timeout: no if_ack within 20 cycles, required one"); end
  endtask

  task automatic test_wrap();
    int exp_a [4] = '{1022, 1023, 0, 1};
    bit seen;
    @(posedge clk); #1;
    ld_addr  = 10'd1022;
    ld_bytes = 4'd4;
    ld_req   = 1'b1;
    push_exp(1'b1, 64'h0100A3A2, cyc + 1 + 4);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (mem_raddr !== 10'(exp_a[k])) begin
        errors++;
        $display("FAIL wrap_beat%0d: got raddr=%0d, required %0d", k, mem_raddr, exp_a[k]);
      end
    end
    wait_ack(1'b1, 20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL wrap_timeout: no ld_ack within 20 cycles, required one"); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    ld_addr  = 10'd0;
    ld_bytes = 4'd8;
    ld_req   = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ((mem_raddr !== 10'd1) || (busy !== 1'b1)) begin
      errors++;
      $display("FAIL abort_beat2: got raddr=%0d busy=%0b, required raddr=1 busy=1", mem_raddr, busy);
    end
    @(posedge clk); #1;
    reset  = 1'b0;
    ld_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ld_ack, if_ack} !== 3'b000) begin errors++; $display("FAIL abort_flags: got busy/ld_ack/if_ack=%b, required 000", {busy, ld_ack, if_ack}); end
    checks++;
    if (ld_data !== 64'h0) begin errors++; $display("FAIL abort_ld_data: got %h, required 0", ld_data); end
    checks++;
    if (mem_raddr !== 10'd0) begin errors++; $display("FAIL abort_raddr: got %0d, required 0", mem_raddr); end
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    if_addr = 10'd4;
    if_req  = 1'b1;
    push_exp(1'b0, 64'h07060504, cyc + 1 + 4);
    wait_ack(1'b0, 20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_fetch_timeout: no if_ack within 20 cycles, required one"); end
  endtask

  task automatic test_addr_change();
    int e;
    bit seen;
    @(posedge clk); #1;
    if_addr = 10'd8;
    if_req  = 1'b1;
    e = cyc + 1;
    push_exp(1'b0, 64'h0B0A0908, e + 4);
    push_exp(1'b1, 64'h0100,     e + 7);
    @(posedge clk); #1;
    if_addr  = 10'd1020;
    ld_addr  = 10'd0;
    ld_bytes = 4'd2;
    ld_req   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ((mem_raddr !== 10'(8 + k)) || (ld_ack !== 1'b0)) begin
        errors++;
        $display("FAIL latch_beat%0d: got raddr=%0d ld_ack=%0b, required raddr=%0d ld_ack=0", k, mem_raddr, ld_ack, 8 + k);
      end
    end
    wait_ack(1'b0, 20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL latch_if_timeout: no if_ack within 20 cycles, required one"); end
    wait_ack(1'b1, 20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL latch_ld_timeout: no ld_ack within 20 cycles, required one"); end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    reset    = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    ld_req   = 1'b0;
    ld_addr  = '0;
    ld_bytes = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 7) + 8'h40);
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[1020] = 8'hA0;
    mem[1021] = 8'hA1;
    mem[1022] = 8'hA2;
    mem[1023] = 8'hA3;

    test_reset();
    test_fetch();
    test_load();
    test_arbitration();
    test_wrap();
    test_reset_mid();
    test_addr_change();

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_acks: %0d expected acks never arrived, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
